// File: rtl/typing_round_ctrl.sv
// typing_round_ctrl: round sequencer for the typing tutor.
// Each round picks a random digit (0-9), strobes it into the display
// register, then judges the next PS/2 make code as a hit or miss, or
// declares a miss if the round's time limit runs out. Hits/misses are
// shown for a fixed feedback period. The game ends after ROUNDS rounds.
// Optional feature: define STREAK_BONUS_EN to add a consecutive-hit
// streak counter that awards a double point (and pulses o_bonus) once
// three hits in a row have already been scored.
module typing_round_ctrl #(
  parameter int ROUNDS          = 10,
  parameter int TIMEOUT_CYCLES  = 100_000_000,
  parameter int FEEDBACK_CYCLES = 25_000_000,
  parameter int CNT_W           = 27
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_rand_digit,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_byte,
  output logic [3:0] o_target,
  output logic       o_target_load,
  output logic       o_hit,
  output logic       o_miss,
  output logic [7:0] o_score,
  output logic [7:0] o_round_no,
`ifdef STREAK_BONUS_EN
  output logic       o_bonus,
`endif
  output logic       o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_KEY,
    S_HIT,
    S_MISS,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FEEDBACK_LAST = CNT_W'(FEEDBACK_CYCLES - 1);
  localparam logic [7:0]       LAST_ROUND    = 8'(ROUNDS);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_break, w_break_next;
  logic             r_ext, w_ext_next;
  logic [3:0]       r_target, w_target_next;
  logic             r_target_load, w_target_load_next;
  logic             r_hit, w_hit_next;
  logic             r_miss, w_miss_next;
  logic [7:0]       r_score, w_score_next;
  logic [7:0]       r_round, w_round_next;
  logic             r_game_over, w_game_over_next;
`ifdef STREAK_BONUS_EN
  logic [1:0]       r_streak, w_streak_next;
  logic             r_bonus, w_bonus_next;
  logic [7:0]       w_score_plus2;
`endif

  logic             w_key_is_digit;
  logic [3:0]       w_key_digit;
  logic             w_is_f0;
  logic             w_is_e0;
  logic             w_make;
  logic             w_discard;
  logic [7:0]       w_score_plus1;

  // Translate a set-2 scan byte into a digit; anything else is a non-digit
  always_comb begin
    w_key_is_digit = 1'b1;
    w_key_digit    = 4'd0;
    case (i_key_byte)
      8'h45:   w_key_digit = 4'd0;
      8'h16:   w_key_digit = 4'd1;
      8'h1E:   w_key_digit = 4'd2;
      8'h26:   w_key_digit = 4'd3;
      8'h25:   w_key_digit = 4'd4;
      8'h2E:   w_key_digit = 4'd5;
      8'h36:   w_key_digit = 4'd6;
      8'h3D:   w_key_digit = 4'd7;
      8'h3E:   w_key_digit = 4'd8;
      8'h46:   w_key_digit = 4'd9;
      default: w_key_is_digit = 1'b0;
    endcase
  end

  assign w_is_f0       = i_key_valid && (i_key_byte == 8'hF0);
  assign w_is_e0       = i_key_valid && (i_key_byte == 8'hE0);
  assign w_make        = i_key_valid && !w_is_f0 && !w_is_e0 && !(r_break || r_ext);
  assign w_discard     = i_key_valid && !w_is_f0 && !w_is_e0 && (r_break || r_ext);
  assign w_score_plus1 = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
`ifdef STREAK_BONUS_EN
  assign w_score_plus2 = (r_score >= 8'hFE) ? 8'hFF : r_score + 8'd2;
`endif

  // Next-state and next-register values; every register holds by default
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_break_next       = r_break;
    w_ext_next         = r_ext;
    w_target_next      = r_target;
    w_target_load_next = 1'b0;
    w_hit_next         = r_hit;
    w_miss_next        = r_miss;
    w_score_next       = r_score;
    w_round_next       = r_round;
    w_game_over_next   = r_game_over;
`ifdef STREAK_BONUS_EN
    w_streak_next      = r_streak;
    w_bonus_next       = r_bonus;
`endif

    if (w_is_f0) begin
      w_break_next = 1'b1;
    end
    if (w_is_e0) begin
      w_ext_next = 1'b1;
    end
    if (w_discard) begin
      w_break_next = 1'b0;
      w_ext_next   = 1'b0;
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_score_next     = 8'd0;
          w_round_next     = 8'd1;
          w_game_over_next = 1'b0;
          w_break_next     = 1'b0;
          w_ext_next       = 1'b0;
`ifdef STREAK_BONUS_EN
          w_streak_next    = 2'd0;
`endif
          w_state_next     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (i_rand_digit <= 4'd9) begin
          w_target_next      = i_rand_digit;
          w_target_load_next = 1'b1;
          w_cnt_next         = '0;
          w_state_next       = S_WAIT_KEY;
        end
      end

      S_WAIT_KEY: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (w_make) begin
          w_cnt_next = '0;
          if (w_key_is_digit && (w_key_digit == r_target)) begin
            w_hit_next   = 1'b1;
            w_state_next = S_HIT;
`ifdef STREAK_BONUS_EN
            if (r_streak == 2'd3) begin
              w_score_next = w_score_plus2;
              w_bonus_next = 1'b1;
            end else begin
              w_score_next  = w_score_plus1;
              w_streak_next = r_streak + 2'd1;
            end
`else
            w_score_next = w_score_plus1;
`endif
          end else begin
            w_miss_next  = 1'b1;
            w_state_next = S_MISS;
`ifdef STREAK_BONUS_EN
            w_streak_next = 2'd0;
`endif
          end
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_cnt_next   = '0;
          w_miss_next  = 1'b1;
          w_state_next = S_MISS;
`ifdef STREAK_BONUS_EN
          w_streak_next = 2'd0;
`endif
        end
      end

      S_HIT, S_MISS: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == FEEDBACK_LAST) begin
          w_cnt_next  = '0;
          w_hit_next  = 1'b0;
          w_miss_next = 1'b0;
`ifdef STREAK_BONUS_EN
          w_bonus_next = 1'b0;
`endif
          if (r_round == LAST_ROUND) begin
            w_game_over_next = 1'b1;
            w_state_next     = S_DONE;
          end else begin
            w_round_next = r_round + 8'd1;
            w_break_next = 1'b0;
            w_ext_next   = 1'b0;
            w_state_next = S_LOAD;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset wins over any in-progress round
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_break       <= 1'b0;
      r_ext         <= 1'b0;
      r_target      <= 4'd0;
      r_target_load <= 1'b0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_score       <= 8'd0;
      r_round       <= 8'd0;
      r_game_over   <= 1'b0;
`ifdef STREAK_BONUS_EN
      r_streak      <= 2'd0;
      r_bonus       <= 1'b0;
`endif
    end else begin
      r_cnt         <= w_cnt_next;
      r_break       <= w_break_next;
      r_ext         <= w_ext_next;
      r_target      <= w_target_next;
      r_target_load <= w_target_load_next;
      r_hit         <= w_hit_next;
      r_miss        <= w_miss_next;
      r_score       <= w_score_next;
      r_round       <= w_round_next;
      r_game_over   <= w_game_over_next;
`ifdef STREAK_BONUS_EN
      r_streak      <= w_streak_next;
      r_bonus       <= w_bonus_next;
`endif
    end
  end

  assign o_target      = r_target;
  assign o_target_load = r_target_load;
  assign o_hit         = r_hit;
  assign o_miss        = r_miss;
  assign o_score       = r_score;
  assign o_round_no    = r_round;
  assign o_game_over   = r_game_over;
`ifdef STREAK_BONUS_EN
  assign o_bonus       = r_bonus;
`endif

endmodule

// File: tb/tb_typing_round_ctrl.sv
// tb_typing_round_ctrl: randomized bench for typing_round_ctrl.
// Games are played round by round; a game-level model (score, round,
// streak, target) predicts when each judgement appears and what it is.
module tb_typing_round_ctrl;

  localparam int TO = 20;
  localparam int FB = 4;
`ifdef STREAK_BONUS_EN
  localparam int NR = 5;
`else
  localparam int NR = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] rand_digit;
  logic       key_valid;
  logic [7:0] key_byte;
  logic [3:0] target;
  logic       target_load;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] round_no;
  logic       game_over;
`ifdef STREAK_BONUS_EN
  logic       bonus;
`endif

  typing_round_ctrl #(
    .ROUNDS(NR),
    .TIMEOUT_CYCLES(TO),
    .FEEDBACK_CYCLES(FB),
    .CNT_W(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_rand_digit(rand_digit),
    .i_key_valid(key_valid),
    .i_key_byte(key_byte),
    .o_target(target),
    .o_target_load(target_load),
    .o_hit(hit),
    .o_miss(miss),
    .o_score(score),
    .o_round_no(round_no),
`ifdef STREAK_BONUS_EN
    .o_bonus(bonus),
`endif
    .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] scanTab [10];
  int mScore;
  int mRound;
  int mStreak;
  int mTarget;

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and return #1 after the capturing edge
  task automatic applyStimulus(input logic st, input logic [3:0] rd, input logic kv, input logic [7:0] kb);
    start      = st;
    rand_digit = rd;
    key_valid  = kv;
    key_byte   = kb;
    @(posedge clk);
    #1;
  endtask

  // A make code that must be judged as a miss for the current target
  function automatic logic [7:0] wrongByte(input int tgt);
    logic [7:0] b;
    if ($urandom_range(0, 1) == 0) begin
      b = scanTab[(tgt + 1 + $urandom_range(0, 8)) % 10];
    end else begin
      do begin
        b = 8'($urandom);
      end while (b == 8'hF0 || b == 8'hE0 || b == scanTab[tgt]);
    end
    return b;
  endfunction

  // Any byte a player might produce, prefixes included
  function automatic logic [7:0] anyByte(input int tgt);
    case ($urandom_range(0, 3))
      0:       return 8'hF0;
      1:       return 8'hE0;
      2:       return scanTab[tgt];
      default: return 8'($urandom);
    endcase
  endfunction

  // Begin a game from IDLE or DONE and check the fresh-game outputs
  task automatic startGame();
    applyStimulus(1'b1, 4'($urandom), 1'b0, 8'h00);
    mScore  = 0;
    mRound  = 1;
    mStreak = 0;
    checkOutput("startRound", round_no, 1);
    checkOutput("startScore", score, 0);
    checkOutput("startGameOver", game_over, 0);
  endtask

  // Offer some out-of-range digits, then a valid one, and expect one strobe
  task automatic loadPhase();
    int nBad;
    int d;
    nBad = $urandom_range(0, 2);
    for (int i = 0; i < nBad; i++) begin
      applyStimulus(1'b0, 4'($urandom_range(10, 15)), 1'b0, 8'h00);
      checkOutput("loadNoStrobe", target_load, 0);
    end
    d = $urandom_range(0, 9);
    applyStimulus(1'b0, 4'(d), 1'b0, 8'h00);
    checkOutput("loadStrobe", target_load, 1);
    checkOutput("loadTarget", target, d);
    mTarget = d;
  endtask

  // Play one round: 0 hit, 1 wrong key, 2 prefixed bytes then a key,
  // 3 timeout, 4 correct key in the timeout cycle
  task automatic playRound(input int mode);
    int  sched [TO];
    int  res;
    int  j0;
    bit  pending;
    bit  isHit;
    bit  expBonus;
    logic       kv;
    logic [7:0] kb;

    loadPhase();

    for (int j = 0; j < TO; j++) sched[j] = -1;
    case (mode)
      0: sched[$urandom_range(0, TO - 1)] = int'(scanTab[mTarget]);
      1: sched[$urandom_range(0, TO - 1)] = int'(wrongByte(mTarget));
      2: begin
        j0 = $urandom_range(0, TO - 6);
        sched[j0] = ($urandom_range(0, 1) == 0) ? 32'hF0 : 32'hE0;
        if ($urandom_range(0, 1) == 1) sched[j0 + 1] = 32'hF0;
        sched[j0 + 2] = int'(scanTab[mTarget]);
        sched[$urandom_range(j0 + 3, TO - 1)] =
          ($urandom_range(0, 1) == 0) ? int'(scanTab[mTarget]) : int'(wrongByte(mTarget));
      end
      3: begin
        if ($urandom_range(0, 1) == 1) begin
          sched[$urandom_range(0, TO - 2)] = 32'hF0;
          sched[TO - 1] = int'(scanTab[mTarget]);
        end
      end
      default: sched[TO - 1] = int'(scanTab[mTarget]);
    endcase

    res = -1;
    pending = 1'b0;
    isHit = 1'b0;
    for (int j = 0; j < TO && res < 0; j++) begin
      if (sched[j] >= 0) begin
        if (sched[j] == 32'hF0 || sched[j] == 32'hE0) begin
          pending = 1'b1;
        end else if (pending) begin
          pending = 1'b0;
        end else begin
          res = j;
          isHit = (sched[j] == int'(scanTab[mTarget]));
        end
      end
    end
    if (res < 0) res = TO - 1;

    for (int j = 0; j <= res; j++) begin
      kv = (sched[j] >= 0);
      kb = kv ? 8'(sched[j]) : 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), kv, kb);
      if (j < res) begin
        checkOutput("waitNoJudge", {hit, miss}, 0);
        checkOutput("waitNoStrobe", target_load, 0);
      end
    end

    expBonus = 1'b0;
    if (isHit) begin
`ifdef STREAK_BONUS_EN
      if (mStreak == 3) begin
        mScore = (mScore + 2 > 255) ? 255 : mScore + 2;
        expBonus = 1'b1;
      end else begin
        mScore = (mScore + 1 > 255) ? 255 : mScore + 1;
        mStreak++;
      end
`else
      mScore = (mScore + 1 > 255) ? 255 : mScore + 1;
`endif
    end else begin
      mStreak = 0;
    end

    checkOutput("judgeHit", hit, isHit);
    checkOutput("judgeMiss", miss, !isHit);
    checkOutput("judgeScore", score, mScore);
    checkOutput("judgeTarget", target, mTarget);
`ifdef STREAK_BONUS_EN
    checkOutput("judgeBonus", bonus, expBonus);
`endif

    for (int k = 1; k < FB; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), anyByte(mTarget));
      checkOutput("fbHit", hit, isHit);
      checkOutput("fbMiss", miss, !isHit);
      checkOutput("fbScore", score, mScore);
`ifdef STREAK_BONUS_EN
      checkOutput("fbBonus", bonus, expBonus);
`endif
    end

    applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), anyByte(mTarget));
    checkOutput("fbEnd", {hit, miss}, 0);
`ifdef STREAK_BONUS_EN
    checkOutput("fbEndBonus", bonus, 0);
`endif
    if (mRound == NR) begin
      checkOutput("endGameOver", game_over, 1);
      checkOutput("endRound", round_no, NR);
    end else begin
      mRound++;
      checkOutput("nextGameOver", game_over, 0);
      checkOutput("nextRound", round_no, mRound);
    end
    checkOutput("fbEndScore", score, mScore);
  endtask

  // Sit in DONE with key traffic and confirm everything stays frozen
  task automatic doneIdle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'($urandom), 1'b1, scanTab[mTarget]);
      checkOutput("doneGameOver", game_over, 1);
      checkOutput("doneScore", score, mScore);
      checkOutput("doneRound", round_no, NR);
      checkOutput("doneQuiet", {hit, miss, target_load}, 0);
    end
  endtask

  // Check every output is at its reset value
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Target"}, target, 0);
    checkOutput({tag, "Load"}, target_load, 0);
    checkOutput({tag, "HitMiss"}, {hit, miss}, 0);
    checkOutput({tag, "Score"}, score, 0);
    checkOutput({tag, "Round"}, round_no, 0);
    checkOutput({tag, "GameOver"}, game_over, 0);
  endtask

  // Directed first game, reset-mid-round, an all-hit game, then random games
  initial begin
    int directedModes [5];
    scanTab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    directedModes = '{4, 2, 3, 0, 1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00);
    checkResetOutputs("por");
    rst_n = 1'b1;

    startGame();
    for (int r = 0; r < NR; r++) playRound(directedModes[r]);
    doneIdle();

    startGame();
    loadPhase();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 8'h00);
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'd7, 1'b1, scanTab[mTarget]);
    checkResetOutputs("midRst");
    applyStimulus(1'b1, 4'd3, 1'b0, 8'h00);
    checkResetOutputs("holdRst");
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd5, 1'b0, 8'h00);
    checkResetOutputs("postRst");

    startGame();
    for (int r = 0; r < NR; r++) playRound(0);
    doneIdle();

    for (int g = 0; g < 6; g++) begin
      startGame();
      for (int r = 0; r < NR; r++) begin
        playRound(($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4));
      end
      doneIdle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/typing_round_ctrl.md
Name: typing_round_ctrl

Overview:
Game sequencer for the typing tutor. Each round it samples the random-digit source, presents a target digit (0-9) to the 7-segment display register, and waits for a PS/2 keystroke within a time limit. It judges the keystroke as hit, miss or timeout, keeps score, and ends the game after a fixed number of rounds. It sits between the PS/2 byte decoder and random generator on the input side, and the display register and LED drivers on the output side.

Parameters:
ROUNDS, 10, rounds per game (1-255)
TIMEOUT_CYCLES, 100_000_000, clk cycles allowed per round before a timeout (1 s at 100 MHz)
FEEDBACK_CYCLES, 25_000_000, clk cycles the hit/miss indication is held before the next round
CNT_W, 27, width of the shared cycle counter; must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, FEEDBACK_CYCLES)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  level; sampled in IDLE/DONE, begins a new game
rand_digit  in  4  free-running random nibble
key_valid  in  1  one-cycle strobe: key_byte holds a new PS/2 scan byte
key_byte  in  8  PS/2 set-2 scan byte
target  out  4  digit to display; register-load data
target_load  out  1  one-cycle strobe: latch target into the display register
hit  out  1  high during hit feedback
miss  out  1  high during miss/timeout feedback
score  out  8  number of hits this game
round_no  out  8  current round, 1-based; 0 in IDLE
game_over  out  1  high in DONE

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; target=0, target_load=0, hit=0, miss=0, score=0, round_no=0, game_over=0, counter=0, break/ext flags cleared. Reset has priority over everything, including mid-round.
- All outputs are registered.
- IDLE: on start=1 clear score and set round_no=1 -> LOAD.
- LOAD: if rand_digit<=9, target<=rand_digit, target_load=1 for exactly one cycle, counter=0 -> WAIT_KEY. If rand_digit>=10, stay in LOAD and resample next cycle (no strobe).
- WAIT_KEY: counter increments every cycle. Filter each key_valid byte:
  - 0xF0 sets break_flag.
  - 0xE0 sets ext_flag.
  - The next non-prefix byte with either flag set is discarded and clears both flags.
  - Any other byte is a make code. It maps to a digit by the set-2 table 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - Make code equal to target -> HIT and score+1, saturating at 255. Any other make code, including non-digits -> MISS.
  - Counter reaching TIMEOUT_CYCLES-1 with no judged key -> MISS.
  - A key judged in the same cycle as the timeout wins.
- HIT / MISS: hit or miss held high for FEEDBACK_CYCLES cycles (counter reset on entry). Key bytes are still filtered for prefixes but never judged. Afterwards: if round_no==ROUNDS -> DONE, else round_no+1 -> LOAD.
- DONE: game_over=1; score and round_no frozen. start=1 -> same as IDLE start; game_over cleared.
- start is ignored outside IDLE/DONE.
- Prefix flags are cleared on entry to LOAD. A stale break code never scores.
- Key latency: key_valid in cycle N -> hit/miss visible at cycle N+1.

Optional Feature:
Macro STREAK_BONUS_EN.
- Defined: add a 2-bit streak counter of consecutive hits, saturating at 3. On a hit with streak already 3, score += 2 (saturating). Miss/timeout clears the streak. Adds output bonus (1 bit), high alongside hit when the bonus applied.
- Undefined: no streak logic, no bonus port, score += 1 per hit only.

Test Plan:
Bench params ROUNDS=3, TIMEOUT_CYCLES=20, FEEDBACK_CYCLES=4.
1. Reset mid-WAIT_KEY (rst_n=0 one cycle) -> next cycle all outputs 0, state IDLE; start ignored until rst_n=1.
2. start, rand_digit=7 -> target_load pulse, target=7. Bytes 0x3D -> hit=1 for 4 cycles, score=1, round_no=2.
3. rand_digit=12 then 3 -> no strobe while 12, target=3 after. Bytes F0,26 -> ignored, no judgement. Then 0x25 -> miss=1, score unchanged.
4. No key for 20 cycles -> miss=1 exactly at cycle 20. Key 0x3D arriving in that same cycle with target=7 -> hit instead.
5. Three rounds all hit -> game_over=1, score=3, round_no=3. start -> score=0, round_no=1, game_over=0.
6. (STREAK_BONUS_EN) four consecutive hits with ROUNDS=5 -> score 1,2,3,5; bonus pulses on the 4th hit; a miss resets the streak.
